// File: rtl/mod_74x165_serializer.sv
// 74x165-style parallel-in/serial-out shift register with a START/BUSY/DONE frame controller.
// Shifts MSB-first toward Q_H, cascades SER into bit 0, and freezes shifting while CLK_INH is high.
module mod_74x165_serializer #(
    parameter int WIDTH = 8,
    parameter int CNT_W = $clog2(WIDTH)
) (
    input  logic             CLK,
    input  logic             RST,
    input  logic             START,
    input  logic [WIDTH-1:0] D,
    input  logic             SER,
    input  logic             CLK_INH,
    output logic             Q_H,
    output logic             Q_H_N,
    output logic             BUSY,
    output logic             DONE
);

    localparam logic [0:0] ST_IDLE  = 1'b0;
    localparam logic [0:0] ST_SHIFT = 1'b1;

    logic [0:0]       r_state;
    logic [WIDTH-1:0] r_shift;
    logic [CNT_W-1:0] r_cnt;
    logic             r_q_h_n;
    logic             r_busy;
    logic             r_done;

    logic [0:0]       w_state_nxt;
    logic [WIDTH-1:0] w_shift_nxt;
    logic [CNT_W-1:0] w_cnt_nxt;
    logic             w_done_nxt;

    // NOTE: every signal gets a default before the branches, so no path leaves one unassigned and no latch is inferred.
    always_comb begin
        w_state_nxt = r_state;
        w_shift_nxt = r_shift;
        w_cnt_nxt   = r_cnt;
        w_done_nxt  = 1'b0;
        if (r_state == ST_IDLE) begin
            // A load is never blocked by CLK_INH.
            if (START) begin
                w_shift_nxt = D;
                w_cnt_nxt   = CNT_W'(WIDTH - 1);
                w_state_nxt = ST_SHIFT;
            end
        end else if (!CLK_INH) begin
            w_shift_nxt = {r_shift[WIDTH-2:0], SER};
            if (r_cnt != '0) begin
                w_cnt_nxt = r_cnt - CNT_W'(1);
            end else begin
                w_state_nxt = ST_IDLE;
                w_done_nxt  = 1'b1;
            end
        end
    end

    // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            r_state <= ST_IDLE;
            r_shift <= '0;
            r_cnt   <= '0;
            r_q_h_n <= 1'b1;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_shift <= w_shift_nxt;
            r_cnt   <= w_cnt_nxt;
            r_q_h_n <= ~w_shift_nxt[WIDTH-1];
            r_busy  <= (w_state_nxt == ST_SHIFT);
            r_done  <= w_done_nxt;
        end
    end

    // Q_H_N has its own flop so both serial outputs come straight from registers.
    assign Q_H   = r_shift[WIDTH-1];
    assign Q_H_N = r_q_h_n;
    assign BUSY  = r_busy;
    assign DONE  = r_done;

endmodule
